// File: rtl/argmin_pkg.sv
// Shared constants, state encoding and sizing helper for the argmin/argmax tracker.
package argmin_pkg;

    localparam int DEF_LANES  = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } argmin_state_t;

    // Lane index width; a single-lane build still carries one index bit.
    function automatic int idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_reduce.sv
// Combinational per-beat winner search across the masked lanes of one beat.
module lane_reduce
    import argmin_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = idx_w(LANES)
) (
    input  logic                    max_sel,
    input  logic [LANES*DATA_W-1:0] data,
    input  logic [LANES-1:0]        mask,
    output logic [DATA_W-1:0]       value,
    output logic [IDX_W-1:0]        index,
    output logic                    any
);

    logic [DATA_W-1:0] cand;

    // Ascending scan with a strict compare, so the lowest lane wins a tie.
    always_comb begin
        value = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                cand = data[i*DATA_W +: DATA_W];
                if (!any || (max_sel ? (cand > value) : (cand < value))) begin
                    value = cand;
                    index = IDX_W'(i);
                end
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/argmin_tracker.sv
// Streaming argmin/argmax search: reduces each beat, then folds the beat winner
// into a running best; the result is offered once the last beat has drained.
module argmin_tracker
    import argmin_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    max_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES-1:0]        in_mask,
    input  logic [ADDR_W-1:0]       in_base,
    input  logic                    in_last,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_best,
    output logic [ADDR_W-1:0]       res_addr,
    output logic                    res_empty,
    output logic [1:0]              state_dbg
);

    localparam int IDX_W = idx_w(LANES);

    argmin_state_t state, state_nxt;

    logic              mode_max;
    logic [DATA_W-1:0] red_value;
    logic [IDX_W-1:0]  red_index;
    logic              red_any;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_value;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_any;

    logic [DATA_W-1:0] best;
    logic [ADDR_W-1:0] best_addr;
    logic              found;

    logic accept;
    logic better;

    // Handshakes: a beat moves when in_valid && in_ready at a rising edge; the
    // result is consumed when res_valid && res_ready. A start pulse takes
    // priority over a beat offered in the same cycle, which is then dropped.
    assign in_ready  = (state == ST_RUN);
    assign res_valid = (state == ST_DONE);
    assign state_dbg = state;
    assign accept    = in_valid && in_ready && !start;
    assign better    = mode_max ? (s1_value > best) : (s1_value < best);

    lane_reduce #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_lane_reduce (
        .max_sel (mode_max),
        .data    (in_data),
        .mask    (in_mask),
        .value   (red_value),
        .index   (red_index),
        .any     (red_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_RUN:   if (accept && in_last) state_nxt = ST_DRAIN;
                ST_DRAIN: if (!s1_valid)         state_nxt = ST_DONE;
                ST_DONE:  if (res_ready)         state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_max  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_value  <= '0;
            s1_addr   <= '0;
            s1_any    <= 1'b0;
            best      <= '0;
            best_addr <= '0;
            found     <= 1'b0;
            res_best  <= '0;
            res_addr  <= '0;
            res_empty <= 1'b0;
        end else if (start) begin
            mode_max  <= max_sel;
            s1_valid  <= 1'b0;
            best      <= max_sel ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
            best_addr <= '0;
            found     <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_value <= red_value;
                s1_addr  <= in_base + ADDR_W'(red_index);
                s1_any   <= red_any;
            end
            // The first participating lane always seeds the best; afterwards
            // only a strictly better value replaces it, keeping the earliest beat.
            if (s1_valid && s1_any && (!found || better)) begin
                best      <= s1_value;
                best_addr <= s1_addr;
                found     <= 1'b1;
            end
            if (state == ST_DRAIN && state_nxt == ST_DONE) begin
                res_best  <= best;
                res_addr  <= found ? best_addr : '0;
                res_empty <= !found;
            end
        end
    end

endmodule

// File: tb/tb_argmin_tracker.sv
// Directed bench for argmin_tracker: one task per scenario with hand-computed results.
module tb_argmin_tracker;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LANES  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    max_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        in_mask;
    logic [ADDR_W-1:0]       in_base;
    logic                    in_last;
    logic                    res_valid;
    logic                    res_ready;
    logic [DATA_W-1:0]       res_best;
    logic [ADDR_W-1:0]       res_addr;
    logic                    res_empty;
    logic [1:0]              state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    argmin_tracker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .max_sel   (max_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_base   (in_base),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_best  (res_best),
        .res_addr  (res_addr),
        .res_empty (res_empty),
        .state_dbg (state_dbg)
    );

    function automatic logic [255:0] pack(input logic [31:0] v0, v1, v2, v3, v4, v5, v6, v7);
        return {v7, v6, v5, v4, v3, v2, v1, v0};
    endfunction

    task automatic do_start(input logic m);
        start = 1'b1;
        max_sel = m;
        @(posedge clk); #1;
        start = 1'b0;
        max_sel = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [7:0] m,
                             input logic [31:0] b, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_data = d; in_mask = m; in_base = b; in_last = l;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL beat_handshake: in_ready=%b after %0d cycles, want 1", in_ready, guard);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; max_sel = 1'b0; in_valid = 1'b0; in_data = '0;
        in_mask = '0; in_base = '0; in_last = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (state_dbg !== 2'd0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: state=%0d in_ready=%b res_valid=%b, want 0/0/0", state_dbg, in_ready, res_valid);
        end
        n_cmp++;
        if (res_best !== 32'd0 || res_addr !== 32'd0 || res_empty !== 1'b0) begin
            n_err++;
            $display("FAIL reset_result: best=%h addr=%h empty=%b, want 0/0/0", res_best, res_addr, res_empty);
        end
        rst = 1'b0;
        in_valid = 1'b1; in_mask = 8'hFF; in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (state_dbg !== 2'd0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignores_valid: state=%0d in_ready=%b, want 0/0", state_dbg, in_ready);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_min_one_beat();
        int lat;
        do_start(1'b0);
        n_cmp++;
        if (state_dbg !== 2'd1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_to_run: state=%0d in_ready=%b, want 1/1", state_dbg, in_ready);
        end
        send_beat(pack(9, 4, 7, 4, 11, 15, 13, 20), 8'hFF, 32'd100, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b0 || state_dbg !== 2'd2) begin
            n_err++;
            $display("FAIL last_to_drain: in_ready=%b state=%0d, want 0/2", in_ready, state_dbg);
        end
        wait_result(lat);
        n_cmp++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL min_latency: got %0d cycles want 2", lat);
        end
        n_cmp++;
        if (res_best !== 32'd4 || res_addr !== 32'd101 || res_empty !== 1'b0) begin
            n_err++;
            $display("FAIL min_result: best=%0d addr=%0d empty=%b, want 4/101/0", res_best, res_addr, res_empty);
        end
        release_result();
        n_cmp++;
        if (state_dbg !== 2'd0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL min_release: state=%0d res_valid=%b, want 0/0", state_dbg, res_valid);
        end
    endtask

    task automatic test_max_three_beats();
        int lat;
        do_start(1'b1);
        send_beat(pack(10, 20, 30, 40, 50, 60, 70, 80), 8'hFF, 32'd0, 1'b0);
        send_beat(pack(100, 200, 300, 500, 499, 5, 6, 7), 8'hFF, 32'd8, 1'b0);
        send_beat(pack(900, 2, 3, 500, 4, 5, 6, 7), 8'hFE, 32'd16, 1'b1);
        wait_result(lat);
        n_cmp++;
        if (lat !== 2 || res_best !== 32'd500 || res_addr !== 32'd11 || res_empty !== 1'b0) begin
            n_err++;
            $display("FAIL max_result: lat=%0d best=%0d addr=%0d empty=%b, want 2/500/11/0", lat, res_best, res_addr, res_empty);
        end
        release_result();
    endtask

    task automatic test_all_masked();
        int lat;
        do_start(1'b0);
        send_beat(pack(0, 0, 0, 0, 0, 0, 0, 0), 8'h00, 32'd40, 1'b0);
        send_beat(pack(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 32'd48, 1'b1);
        wait_result(lat);
        n_cmp++;
        if (lat !== 2 || res_empty !== 1'b1 || res_addr !== 32'd0 || res_best !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL empty_result: lat=%0d empty=%b addr=%h best=%h, want 2/1/0/ffffffff", lat, res_empty, res_addr, res_best);
        end
        release_result();
    endtask

    task automatic test_wrap();
        int lat;
        do_start(1'b0);
        send_beat(pack(50, 40, 30, 2, 60, 70, 80, 90), 8'hFF, 32'hFFFF_FFFE, 1'b1);
        wait_result(lat);
        n_cmp++;
        if (res_best !== 32'd2 || res_addr !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL wrap_addr: best=%0d addr=%h, want 2/00000001", res_best, res_addr);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        do_start(1'b0);
        send_beat(pack(33, 22, 11, 44, 55, 66, 77, 88), 8'hFF, 32'd200, 1'b1);
        wait_result(lat);
        in_valid = 1'b1; in_data = pack(0, 0, 0, 0, 0, 0, 0, 0); in_mask = 8'hFF; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (res_valid !== 1'b1 || res_best !== 32'd11 || res_addr !== 32'd202 ||
                res_empty !== 1'b0 || in_ready !== 1'b0 || state_dbg !== 2'd3) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid=%b best=%0d addr=%0d empty=%b in_ready=%b state=%0d, want 1/11/202/0/0/3",
                         i, res_valid, res_best, res_addr, res_empty, in_ready, state_dbg);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        release_result();
        n_cmp++;
        if (state_dbg !== 2'd0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: state=%0d res_valid=%b, want 0/0", state_dbg, res_valid);
        end
    endtask

    task automatic test_abort_restart();
        int lat;
        do_start(1'b0);
        send_beat(pack(1, 100, 100, 100, 100, 100, 100, 100), 8'hFF, 32'd300, 1'b0);
        @(posedge clk); #1;
        do_start(1'b0);
        n_cmp++;
        if (state_dbg !== 2'd1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL restart_run: state=%0d in_ready=%b, want 1/1", state_dbg, in_ready);
        end
        send_beat(pack(50, 60, 0, 0, 0, 0, 0, 0), 8'h03, 32'd400, 1'b1);
        wait_result(lat);
        n_cmp++;
        if (lat !== 2 || res_best !== 32'd50 || res_addr !== 32'd400) begin
            n_err++;
            $display("FAIL restart_result: lat=%0d best=%0d addr=%0d, want 2/50/400", lat, res_best, res_addr);
        end
        // Restart straight out of DONE without consuming the result.
        do_start(1'b1);
        n_cmp++;
        if (res_valid !== 1'b0 || state_dbg !== 2'd1) begin
            n_err++;
            $display("FAIL restart_from_done: res_valid=%b state=%0d, want 0/1", res_valid, state_dbg);
        end
        send_beat(pack(5, 7, 6, 0, 0, 0, 0, 0), 8'h07, 32'd20, 1'b1);
        wait_result(lat);
        n_cmp++;
        if (res_best !== 32'd7 || res_addr !== 32'd21) begin
            n_err++;
            $display("FAIL restart_max_result: best=%0d addr=%0d, want 7/21", res_best, res_addr);
        end
        release_result();
    endtask

    task automatic test_rst_drain();
        logic seen;
        do_start(1'b0);
        send_beat(pack(3, 8, 8, 8, 8, 8, 8, 8), 8'hFF, 32'd0, 1'b1);
        n_cmp++;
        if (state_dbg !== 2'd2) begin
            n_err++;
            $display("FAIL rst_pre_drain: state=%0d want 2", state_dbg);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (state_dbg !== 2'd0 || res_valid !== 1'b0 || res_best !== 32'd0) begin
            n_err++;
            $display("FAIL rst_async: state=%0d res_valid=%b best=%0d, want 0/0/0", state_dbg, res_valid, res_best);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL rst_no_result: seen_valid=%b state=%0d, want 0/0", seen, state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_min_one_beat();
        test_max_three_beats();
        test_all_masked();
        test_wrap();
        test_backpressure();
        test_abort_restart();
        test_rst_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/argmin_tracker.md
ARGMIN_TRACKER -- requirements
Module: argmin_tracker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each candidate value.
REQ-002 SHALL have parameter ADDR_W, default 32, width of addresses.
REQ-003 SHALL have parameter LANES, default 8, candidates per beat; legal range 1..16.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a new search.
REQ-007 SHALL have port max_sel  input  1  0 = search minimum, 1 = search maximum; sampled when start is high.
REQ-008 SHALL have port in_valid  input  1  beat offered.
REQ-009 SHALL have port in_ready  output  1  beat can be accepted.
REQ-010 SHALL have port in_data  input  LANES*DATA_W  candidates; lane i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port in_mask  input  LANES  lane i participates when bit i = 1.
REQ-012 SHALL have port in_base  input  ADDR_W  address of lane 0.
REQ-013 SHALL have port in_last  input  1  marks final beat of the search.
REQ-014 SHALL have port res_valid  output  1  result available.
REQ-015 SHALL have port res_ready  input  1  result consumed.
REQ-016 SHALL have port res_best  output  DATA_W  winning value.
REQ-017 SHALL have port res_addr  output  ADDR_W  address of winning value.
REQ-018 SHALL have port res_empty  output  1  no lane participated during the search.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-020 SHALL move IDLE->RUN on start, clearing the running best to all-ones (min) or zero (max), found=0, and latching max_sel.
REQ-021 SHALL assert in_ready only in RUN; a beat transfers when in_valid and in_ready are both high.
REQ-022 SHALL, in the cycle after a transfer, register the in-beat winner (value, lane index, any-lane flag); lanes with mask 0 are excluded.
REQ-023 SHALL, one cycle later, compare that winner with the running best and replace it only on strictly better (unsigned compare), setting found=1.
REQ-024 SHALL resolve ties to the lowest lane index within a beat and to the earliest beat across beats.
REQ-025 SHALL compute address as in_base + lane index, modulo 2^ADDR_W (wrap-around permitted).
REQ-026 SHALL leave the running best unchanged for a beat whose in_mask is all zero.
REQ-027 SHALL go RUN->DRAIN on a transfer with in_last=1, deasserting in_ready the next cycle.
REQ-028 SHALL go DRAIN->DONE when the pipeline is empty; res_valid rises exactly 2 cycles after the in_last transfer.
REQ-029 SHALL hold res_best, res_addr, res_empty stable in DONE while res_valid=1 and res_ready=0.
REQ-030 SHALL go DONE->IDLE in the cycle res_valid and res_ready are both high.
REQ-031 SHALL drive res_empty=1, res_addr=0, res_best=initial value when found=0 at DONE.
REQ-032 SHALL treat start in RUN, DRAIN or DONE as abort-and-restart: pipeline flushed, res_valid dropped, state RUN next cycle.
REQ-033 SHALL ignore in_valid while not in RUN (no state change).

Reset
REQ-034 SHALL on rst force state IDLE, in_ready=0, res_valid=0, res_best=0, res_addr=0, res_empty=0, pipeline valid flags 0, max_sel latch 0.
REQ-035 SHALL abandon any search in progress on rst with no result produced.

Structure
REQ-036 SHALL place the state enumeration and default LANES/DATA_W/ADDR_W constants in shared package argmin_pkg.
REQ-037 SHALL implement the per-beat lane comparison tree as combinational sub-module lane_reduce (parameters LANES, DATA_W; outputs value, index, any).

Verification
REQ-038 SHALL cover: min mode, one beat, base 100, lanes {9,4,7,4,...,20} all masked -> res_best=4, res_addr=101, res_valid 2 cycles after transfer.
REQ-039 SHALL cover: max mode, 3 beats with base 0,8,16 and global max 500 at beat 2 lane 3 -> res_best=500, res_addr=11.
REQ-040 SHALL cover: in_mask=0x00 on every beat -> res_empty=1, res_addr=0, res_best=0xFFFFFFFF (min mode).
REQ-041 SHALL cover: in_base=0xFFFFFFFE, winner lane 3 -> res_addr=0x00000001.
REQ-042 SHALL cover: res_ready held low 5 cycles -> outputs stable, no new beats accepted, IDLE the cycle after handshake.
REQ-043 SHALL cover: start mid-RUN after a beat containing 1, then beat of {50,60} -> res_best=50 (old value discarded); rst mid-DRAIN -> res_valid never rises.
